// File: rtl/cfg_reg_pkg.sv
// cfg_reg_pkg: shared constants and types for the configuration register bank.
//   CFG_NUM_REGS / CFG_ADDR_W / CFG_DATA_W : default geometry of cfg_reg_ctrl
//   REG_*                                  : register address map (1-based)
//   grant_e                                : arbiter grant identity
package cfg_reg_pkg;

    localparam int unsigned CFG_NUM_REGS = 5;
    localparam int unsigned CFG_ADDR_W   = 7;
    localparam int unsigned CFG_DATA_W   = 8;

    localparam int unsigned REG_OUT_LO = 1;
    localparam int unsigned REG_OUT_HI = 2;
    localparam int unsigned REG_PWM_LO = 3;
    localparam int unsigned REG_PWM_HI = 4;
    localparam int unsigned REG_DUTY   = 5;

    typedef enum logic {
        GRANT_HOST = 1'b0,
        GRANT_SPI  = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter (HOST, SPI).
//   clk, rst        : clock, asynchronous active-high reset
//   req_host_i      : host requester
//   req_spi_i       : SPI requester
//   gnt_host_o      : host granted this cycle
//   gnt_spi_o       : SPI granted this cycle
//   last_grant_o    : requester granted most recently (HOST after reset)
module rr_arb2
    import cfg_reg_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_host_i,
    input  logic   req_spi_i,
    output logic   gnt_host_o,
    output logic   gnt_spi_o,
    output grant_e last_grant_o
);

    grant_e last_q, last_d;
    logic   gnt_host, gnt_spi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GRANT_HOST;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt_host = 1'b0;
        gnt_spi  = 1'b0;
        last_d   = last_q;
        if (req_host_i && req_spi_i) begin
            // Contention: favour whoever was not served last.
            if (last_q == GRANT_SPI) begin
                gnt_host = 1'b1;
            end else begin
                gnt_spi = 1'b1;
            end
        end else begin
            gnt_host = req_host_i;
            gnt_spi  = req_spi_i;
        end
        if (gnt_host) begin
            last_d = GRANT_HOST;
        end else if (gnt_spi) begin
            last_d = GRANT_SPI;
        end
    end

    assign gnt_host_o   = gnt_host;
    assign gnt_spi_o    = gnt_spi;
    assign last_grant_o = last_q;

endmodule

// File: rtl/cfg_reg_ctrl.sv
// cfg_reg_ctrl: configuration register bank controller.
// Owns NUM_REGS data registers (addresses 1..NUM_REGS), arbitrates one write
// per cycle between a one-entry SPI slot and a host port, and optionally
// stages writes in shadow registers committed on a period-boundary strobe.
// Build option: define CFG_REG_SHADOW_EN to enable shadow/commit staging.
//   clk, rst                      : clock, asynchronous active-high reset
//   spi_wr_valid/addr/data        : one-cycle SPI write pulse (no backpressure)
//   host_wr_valid/ready/addr/data : host write handshake
//   commit                        : period-boundary strobe (shadow build only)
//   reg_out                       : active registers, reg 1 in the low byte
//   pending                       : some shadow register is uncommitted
//   err_addr                      : pulse after a granted out-of-range write
//   spi_ovf                       : sticky, an SPI write was overwritten in the slot
module cfg_reg_ctrl
    import cfg_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS = CFG_NUM_REGS,
    parameter int unsigned ADDR_W   = CFG_ADDR_W,
    parameter int unsigned DATA_W   = CFG_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_wr_valid,
    input  logic [ADDR_W-1:0]          spi_wr_addr,
    input  logic [DATA_W-1:0]          spi_wr_data,
    input  logic                       host_wr_valid,
    output logic                       host_wr_ready,
    input  logic [ADDR_W-1:0]          host_wr_addr,
    input  logic [DATA_W-1:0]          host_wr_data,
    input  logic                       commit,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic                       pending,
    output logic                       err_addr,
    output logic                       spi_ovf
);

    logic              slot_full_q, slot_full_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [DATA_W-1:0] slot_data_q, slot_data_d;
    logic              spi_ovf_q, spi_ovf_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              gnt_host, gnt_spi, wr_en;
    grant_e            last_grant;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_REGS-1:0] wr_hit;

`ifdef CFG_REG_SHADOW_EN
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

    rr_arb2 u_arb (
        .clk          (clk),
        .rst          (rst),
        .req_host_i   (host_wr_valid),
        .req_spi_i    (slot_full_q),
        .gnt_host_o   (gnt_host),
        .gnt_spi_o    (gnt_spi),
        .last_grant_o (last_grant)
    );

    // Equivalent to "host would win if it asked", so it never depends on host_wr_valid.
    assign host_wr_ready = !slot_full_q || (last_grant == GRANT_SPI);

    assign wr_en   = gnt_host || gnt_spi;
    assign wr_addr = gnt_spi ? slot_addr_q : host_wr_addr;
    assign wr_data = gnt_spi ? slot_data_q : host_wr_data;

    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = wr_en && (wr_addr == ADDR_W'(i + 1));
        end
        err_d = wr_en && (wr_hit == '0);
    end

    always_comb begin
        slot_full_d = slot_full_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        spi_ovf_d   = spi_ovf_q;
        if (spi_wr_valid) begin
            // A reload in the cycle the old entry is granted is not a loss.
            if (slot_full_q && !gnt_spi) begin
                spi_ovf_d = 1'b1;
            end
            slot_full_d = 1'b1;
            slot_addr_d = spi_wr_addr;
            slot_data_d = spi_wr_data;
        end else if (gnt_spi) begin
            slot_full_d = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
`ifdef CFG_REG_SHADOW_EN
        shadow_d = shadow_q;
        dirty_d  = dirty_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            // Commit reads the old shadow, so a coincident write stays staged.
            if (commit && dirty_q[i]) begin
                regs_d[i]  = shadow_q[i];
                dirty_d[i] = 1'b0;
            end
            if (wr_hit[i]) begin
                shadow_d[i] = wr_data;
                dirty_d[i]  = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_hit[i]) begin
                regs_d[i] = wr_data;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full_q <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            spi_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
`ifdef CFG_REG_SHADOW_EN
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
            dirty_q <= '0;
`endif
        end else begin
            slot_full_q <= slot_full_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            spi_ovf_q   <= spi_ovf_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
`ifdef CFG_REG_SHADOW_EN
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
`endif
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

`ifdef CFG_REG_SHADOW_EN
    assign pending = |dirty_q;
`else
    assign pending = 1'b0;
`endif
    assign err_addr = err_q;
    assign spi_ovf  = spi_ovf_q;

endmodule

// File: tb/tb_cfg_reg_ctrl.sv
// tb_cfg_reg_ctrl: self-checking bench for cfg_reg_ctrl (either build of
// CFG_REG_SHADOW_EN). Directed vector table, a reset-in-flight sequence,
// then randomized traffic checked against a behavioural model.
module tb_cfg_reg_ctrl;
    import cfg_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_wr_valid;
    logic [6:0]  spi_wr_addr;
    logic [7:0]  spi_wr_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [6:0]  host_wr_addr;
    logic [7:0]  host_wr_data;
    logic        commit;
    logic [39:0] reg_out;
    logic        pending;
    logic        err_addr;
    logic        spi_ovf;

    int n_vec  = 0;
    int n_miss = 0;

    cfg_reg_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .spi_wr_valid  (spi_wr_valid),
        .spi_wr_addr   (spi_wr_addr),
        .spi_wr_data   (spi_wr_data),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .commit        (commit),
        .reg_out       (reg_out),
        .pending       (pending),
        .err_addr      (err_addr),
        .spi_ovf       (spi_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          hv;
        logic [6:0]  ha;
        logic [7:0]  hd;
        bit          sv;
        logic [6:0]  sa;
        logic [7:0]  sd;
        bit          cm;
        bit          e_rdy;
        logic [39:0] e_reg;
        bit          e_pend;
        bit          e_err;
        bit          e_ovf;
    } vec_t;

    vec_t vt[$];

    // ---------------- behavioural reference model ----------------
    bit         m_full;
    logic [6:0] m_sa;
    logic [7:0] m_sd;
    bit         m_last_spi;
    logic [7:0] m_reg [5];
    logic [7:0] m_sh  [5];
    bit         m_dirty [5];
    bit         m_err;
    bit         m_ovf;

    task automatic model_reset();
        m_full = 0; m_sa = '0; m_sd = '0; m_last_spi = 0; m_err = 0; m_ovf = 0;
        for (int i = 0; i < 5; i++) begin
            m_reg[i] = '0; m_sh[i] = '0; m_dirty[i] = 0;
        end
    endtask

    function automatic bit model_ready();
        return !m_full || m_last_spi;
    endfunction

    function automatic logic [39:0] model_regout();
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = m_reg[i];
        return r;
    endfunction

    function automatic bit model_pending();
        bit p = 0;
`ifdef CFG_REG_SHADOW_EN
        for (int i = 0; i < 5; i++) p = p | m_dirty[i];
`endif
        return p;
    endfunction

    task automatic model_clock(input bit hv, input logic [6:0] ha, input logic [7:0] hd,
                               input bit sv, input logic [6:0] sa, input logic [7:0] sd,
                               input bit cm);
        bit gh, gs;
        logic [6:0] a;
        logic [7:0] d;
        int idx;
        if (hv && m_full) begin
            gh = m_last_spi; gs = !m_last_spi;
        end else begin
            gh = hv; gs = m_full;
        end
        if (gh) m_last_spi = 0;
        if (gs) m_last_spi = 1;
        a = gs ? m_sa : ha;
        d = gs ? m_sd : hd;
        idx = int'(a) - 1;
        m_err = (gh || gs) && !(a >= 1 && a <= 5);
`ifdef CFG_REG_SHADOW_EN
        for (int i = 0; i < 5; i++) begin
            if (cm && m_dirty[i]) begin
                m_reg[i] = m_sh[i]; m_dirty[i] = 0;
            end
        end
        if ((gh || gs) && !m_err) begin
            m_sh[idx] = d; m_dirty[idx] = 1;
        end
`else
        if (cm) idx = idx;  // commit has no effect without shadowing
        if ((gh || gs) && !m_err) m_reg[idx] = d;
`endif
        if (sv) begin
            if (m_full && !gs) m_ovf = 1;
            m_full = 1; m_sa = sa; m_sd = sd;
        end else if (gs) begin
            m_full = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit hv, input logic [6:0] ha, input logic [7:0] hd,
                         input bit sv, input logic [6:0] sa, input logic [7:0] sd,
                         input bit cm);
        host_wr_valid = hv; host_wr_addr = ha; host_wr_data = hd;
        spi_wr_valid  = sv; spi_wr_addr  = sa; spi_wr_data  = sd;
        commit        = cm;
    endtask

    initial begin
        bit         hv;
        logic [6:0] ha;
        logic [7:0] hd;
        bit         sv;
        logic [6:0] sa;
        logic [7:0] sd;
        bit         cm;
        bit         acc;

        rst = 1'b1;
        drive(0, '0, '0, 0, '0, '0, 0);
        repeat (2) @(negedge clk);
        chk("reset_reg_out", 64'(reg_out), 64'h0);
        chk("reset_pending", 64'(pending), 64'h0);
        chk("reset_err", 64'(err_addr), 64'h0);
        chk("reset_ovf", 64'(spi_ovf), 64'h0);
        chk("reset_ready", 64'(host_wr_ready), 64'h1);
        rst = 1'b0;

`ifdef CFG_REG_SHADOW_EN
        vt.push_back('{1, 7'd5, 8'h80, 0, 7'd0, 8'h00, 0, 1, 40'h0000000000, 1, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 1, 40'h0000000000, 1, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1, 1, 40'h8000000000, 0, 0, 0});
        vt.push_back('{1, 7'd4, 8'h11, 0, 7'd0, 8'h00, 0, 1, 40'h8000000000, 1, 0, 0});
        vt.push_back('{1, 7'd4, 8'h22, 0, 7'd0, 8'h00, 1, 1, 40'h8011000000, 1, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1, 1, 40'h8022000000, 0, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 1, 7'd1, 8'hA5, 0, 1, 40'h8022000000, 0, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 0, 40'h8022000000, 1, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1, 1, 40'h80220000A5, 0, 0, 0});
`else
        vt.push_back('{1, 7'(REG_PWM_LO), 8'h5A, 0, 7'd0, 8'h00, 0, 1, 40'h00005A0000, 0, 0, 0});
        vt.push_back('{1, 7'd2, 8'h3C, 1, 7'd1, 8'hA5, 0, 1, 40'h00005A3C00, 0, 0, 0});
        vt.push_back('{1, 7'd2, 8'h3C, 0, 7'd0, 8'h00, 0, 0, 40'h00005A3CA5, 0, 0, 0});
        vt.push_back('{1, 7'd2, 8'h3C, 0, 7'd0, 8'h00, 0, 1, 40'h00005A3CA5, 0, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 1, 7'd4, 8'h11, 0, 1, 40'h00005A3CA5, 0, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 0, 40'h00115A3CA5, 0, 0, 0});
        vt.push_back('{0, 7'd0, 8'h00, 1, 7'd4, 8'h22, 0, 1, 40'h00115A3CA5, 0, 0, 0});
        vt.push_back('{1, 7'(REG_DUTY), 8'h77, 1, 7'd4, 8'h33, 1, 1, 40'h77115A3CA5, 0, 0, 1});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 0, 40'h77335A3CA5, 0, 0, 1});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 1, 40'h77335A3CA5, 0, 0, 1});
        vt.push_back('{1, 7'd0, 8'hFF, 0, 7'd0, 8'h00, 0, 1, 40'h77335A3CA5, 0, 1, 1});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 1, 40'h77335A3CA5, 0, 0, 1});
        vt.push_back('{1, 7'd6, 8'hEE, 0, 7'd0, 8'h00, 0, 1, 40'h77335A3CA5, 0, 1, 1});
        vt.push_back('{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 1, 40'h77335A3CA5, 0, 0, 1});
`endif

        foreach (vt[k]) begin
            @(negedge clk);
            drive(vt[k].hv, vt[k].ha, vt[k].hd, vt[k].sv, vt[k].sa, vt[k].sd, vt[k].cm);
            #1;
            chk($sformatf("tbl%0d_ready", k), 64'(host_wr_ready), 64'(vt[k].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_reg_out", k), 64'(reg_out), 64'(vt[k].e_reg));
            chk($sformatf("tbl%0d_pending", k), 64'(pending), 64'(vt[k].e_pend));
            chk($sformatf("tbl%0d_err", k), 64'(err_addr), 64'(vt[k].e_err));
            chk($sformatf("tbl%0d_ovf", k), 64'(spi_ovf), 64'(vt[k].e_ovf));
        end

        // Reset in flight: slot loaded and a write taken, then async reset mid-cycle.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 7'd3, 8'h44, 1, 7'd2, 8'h99, 0);
        @(posedge clk);
        #3;
        drive(0, '0, '0, 0, '0, '0, 0);
`ifdef CFG_REG_SHADOW_EN
        chk("midrst_pre_pending", 64'(pending), 64'h1);
`else
        chk("midrst_pre_reg_out", 64'(reg_out), 64'h0000440000);
`endif
        rst = 1'b1;
        #1;
        chk("midrst_reg_out", 64'(reg_out), 64'h0);
        chk("midrst_pending", 64'(pending), 64'h0);
        chk("midrst_ovf", 64'(spi_ovf), 64'h0);
        chk("midrst_ready", 64'(host_wr_ready), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, '0, '0, 0, '0, '0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("postrst_reg_out", 64'(reg_out), 64'h0);
        chk("postrst_err", 64'(err_addr), 64'h0);

        // Randomized traffic against the model.
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        hv = 0; ha = '0; hd = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 700 == 699) begin
                rst = 1'b1;
                model_reset();
                hv = 0;
                #1;
                chk("rand_rst_reg_out", 64'(reg_out), 64'(model_regout()));
                rst = 1'b0;
            end
            if (!hv && $urandom_range(0, 2) == 0) begin
                hv = 1;
                ha = 7'($urandom_range(0, 7));
                hd = 8'($urandom);
            end
            sv = ($urandom_range(0, 2) == 0);
            sa = 7'($urandom_range(0, 7));
            sd = 8'($urandom);
            cm = ($urandom_range(0, 5) == 0);
            drive(hv, ha, hd, sv, sa, sd, cm);
            #1;
            chk("rand_ready", 64'(host_wr_ready), 64'(model_ready()));
            acc = hv && model_ready();
            model_clock(hv, ha, hd, sv, sa, sd, cm);
            @(posedge clk);
            #1;
            chk("rand_reg_out", 64'(reg_out), 64'(model_regout()));
            chk("rand_pending", 64'(pending), 64'(model_pending()));
            chk("rand_err", 64'(err_addr), 64'(m_err));
            chk("rand_ovf", 64'(spi_ovf), 64'(m_ovf));
            if (acc) hv = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
